uart_rx_unit: RTL and testbench
===============================

// Module: uart_rx_unit
// PURPOSE
//  Serial-to-parallel receive path of the 8N1 UART: 16x oversampled start/data/stop detection
//  on the rx line, with a small show-ahead FIFO drained by the host via rd_uart/r_data.
//  It is the receive counterpart of the wr_uart/w_data transmit path, and sits beside it in the UART top.
// PARAMETERS
//  DBIT     8    data bits per frame, sent LSB first
//  SB_TICK  16   oversample ticks in the stop bit (16 = 1 stop bit)
//  DVSR     651  clk cycles per oversample tick (100 MHz / (16*9600))
//  ADDR_W   2    FIFO address width; depth = 2**ADDR_W = 4
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       synchronous reset, active-low
//  rx           in   1       serial input, idle high, asynchronous to clk
//  rd_uart      in   1       pop head byte this cycle (ignored when rx_empty=1)
//  r_data       out  DBIT    FIFO head byte (show-ahead), valid when rx_empty=0
//  rx_empty     out  1       FIFO holds no bytes
//  rx_full      out  1       FIFO holds 2**ADDR_W bytes
//  frame_err    out  1       1-cycle pulse: stop bit sampled low, byte discarded
//  overrun_err  out  1       1-cycle pulse: byte received while FIFO full, byte discarded
// BEHAVIOUR
//  Reset (rst=0 at posedge): FSM=IDLE; all counters 0; sync flops=1; FIFO ptrs 0; mem cleared.
//   Outputs: r_data=0, rx_empty=1, rx_full=0, frame_err=0, overrun_err=0. Reset mid-frame aborts the frame.
//  Tick gen: counter runs 0..DVSR-1 free; tick=1 for one clk when count==DVSR-1.
//  rx passes a 2-flop synchronizer; the FSM sees only the synced value rs.
//  FSM (s = tick counter 0..15, n = bit counter, b = shift reg). s, n and b advance only on tick.
//   IDLE : rs==0 -> START, s=0 (no tick needed).
//   START: on tick, if s==7: rs==0 -> DATA, s=0, n=0; rs==1 -> IDLE (glitch, nothing pushed).
//          Otherwise s++.
//   DATA : on tick, if s==15: b={rs,b[DBIT-1:1]}, s=0; n==DBIT-1 -> STOP, else n++. Otherwise s++.
//   STOP : on tick, if s==SB_TICK-1: -> IDLE.
//          rs==1 -> push b; rs==0 -> frame_err pulse, no push. Otherwise s++.
//  So each bit is sampled at mid-bit; one bit = 16*DVSR clk.
//   After STOP the FSM is in IDLE again, so a back-to-back start bit is accepted immediately.
//  Push is asserted in the cycle of the final STOP tick.
//   rx_empty falls and r_data is valid on the next clk (latency 1).
//  FIFO: r_data = mem[rd_ptr], combinational from the registered pointer/mem.
//   Pointers wrap mod 2**ADDR_W.
//   - pop when empty: ignored, no state change.
//   - push when full and no pop: byte dropped, overrun_err pulse, contents unchanged.
//   - push+pop same cycle, not empty: both happen, count unchanged (allowed even when full, no overrun).
//   - push+pop when empty: the pop is ignored and the push happens.
//  rx_empty/rx_full are registered and update on the same edge as the pointers.
//  frame_err and overrun_err are never asserted together. Both are 0 otherwise.
// TESTING (sim with DVSR=4, so one bit = 64 clk; defaults otherwise)
//  1. Reset, then idle rx=1 for 2000 clk -> rx_empty=1, r_data=0, no error pulses.
//  2. Drive frame 8'h5E (start, bits 0,1,1,1,1,0,1,0, stop) -> rx_empty falls 1 clk after the final
//     stop tick; r_data=8'h5E. Then rd_uart=1 for 1 clk -> rx_empty=1.
//  3. Glitch: rx low for 16 clk (4 ticks), then high -> FSM returns to IDLE, rx_empty stays 1, no frame_err.
//  4. Frame 8'hA5 with stop bit driven 0 -> frame_err one 1-clk pulse, FIFO unchanged (rx_empty=1).
//  5. Five back-to-back frames 01,02,03,04,05, no reads -> rx_full=1 after the 4th frame;
//     overrun_err pulses on the 5th. Reads then return 01,02,03,04, then rx_empty=1.
//  6. rst=0 mid-DATA of a frame, with 2 bytes in the FIFO -> rx_empty=1, r_data=0.
//     The next full frame 8'h3C is received correctly.

Source files
------------

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver: 16x oversampled frame detection feeding a small show-ahead FIFO.
// The host drains bytes through rd_uart/r_data; framing and overrun faults are flagged as 1-clk pulses.
module uart_rx_unit #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int DVSR    = 651,
   parameter int ADDR_W  = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rx,
   input  logic            rd_uart,
   output logic [DBIT-1:0] r_data,
   output logic            rx_empty,
   output logic            rx_full,
   output logic            frame_err,
   output logic            overrun_err
);
   localparam int CNT_W = (DVSR > 1) ? $clog2(DVSR) : 1;
   localparam int S_W   = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // ---------------- oversample tick and input synchronizer ----------------
   logic [CNT_W-1:0] cnt_reg;
   logic             tick;
   logic [1:0]       sync_reg;
   logic             rs;

   assign tick = (cnt_reg == CNT_W'(DVSR - 1));
   assign rs   = sync_reg[1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_reg  <= '0;
         sync_reg <= 2'b11;
      end else begin
         cnt_reg  <= tick ? '0 : cnt_reg + CNT_W'(1);
         sync_reg <= {sync_reg[0], rx};
      end
   end

   // ---------------- receive FSM ----------------
   state_t          state_reg, state_next;
   logic [S_W-1:0]  s_reg, s_next;
   logic [N_W-1:0]  n_reg, n_next;
   logic [DBIT-1:0] b_reg, b_next;
   logic            push;
   logic            frame_bad;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         s_reg     <= '0;
         n_reg     <= '0;
         b_reg     <= '0;
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         n_reg     <= n_next;
         b_reg     <= b_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      n_next     = n_reg;
      b_next     = b_reg;
      push       = 1'b0;
      frame_bad  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!rs) begin
               state_next = START;
               s_next     = '0;
            end
         end
         START: begin
            // A start bit that is no longer low at mid-bit was a glitch.
            if (tick) begin
               if (s_reg == S_W'(7)) begin
                  s_next = '0;
                  n_next = '0;
                  state_next = rs ? IDLE : DATA;
               end else begin
                  s_next = s_reg + S_W'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s_reg == S_W'(15)) begin
                  b_next = {rs, b_reg[DBIT-1:1]};
                  s_next = '0;
                  if (n_reg == N_W'(DBIT - 1)) state_next = STOP;
                  else                        n_next = n_reg + N_W'(1);
               end else begin
                  s_next = s_reg + S_W'(1);
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (s_reg == S_W'(SB_TICK - 1)) begin
                  state_next = IDLE;
                  push       = rs;
                  frame_bad  = !rs;
               end else begin
                  s_next = s_reg + S_W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- show-ahead FIFO ----------------
   logic [DBIT-1:0]   mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
   logic              full_reg, full_next, empty_reg, empty_next;
   logic              wr_en, rd_en;
   logic              frame_err_reg, overrun_err_reg;

   // A full FIFO still accepts a push when a pop frees the head in the same cycle.
   assign rd_en = rd_uart && !empty_reg;
   assign wr_en = push && (!full_reg || rd_en);

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      full_next   = full_reg;
      empty_next  = empty_reg;
      case ({wr_en, rd_en})
         2'b01: begin
            rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
            full_next   = 1'b0;
            empty_next  = (rd_ptr_next == wr_ptr_reg);
         end
         2'b10: begin
            wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
            empty_next  = 1'b0;
            full_next   = (wr_ptr_next == rd_ptr_reg);
         end
         2'b11: begin
            wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
            rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         full_reg        <= 1'b0;
         empty_reg       <= 1'b1;
         frame_err_reg   <= 1'b0;
         overrun_err_reg <= 1'b0;
      end else begin
         if (wr_en) mem[wr_ptr_reg] <= b_reg;
         wr_ptr_reg      <= wr_ptr_next;
         rd_ptr_reg      <= rd_ptr_next;
         full_reg        <= full_next;
         empty_reg       <= empty_next;
         frame_err_reg   <= frame_bad;
         overrun_err_reg <= push && full_reg && !rd_en;
      end
   end

   assign r_data      = mem[rd_ptr_reg];
   assign rx_empty    = empty_reg;
   assign rx_full     = full_reg;
   assign frame_err   = frame_err_reg;
   assign overrun_err = overrun_err_reg;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit with DVSR=4: frames are driven bit by bit, expected bytes
// are queued as each frame is sent and compared as the host pops them.
module tb_uart_rx_unit;
   localparam int DVSR    = 4;
   localparam int BIT_CLK = 16 * DVSR;
   localparam int DEPTH   = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx = 1'b1;
   logic       rd_uart = 1'b0;
   logic [7:0] r_data;
   logic       rx_empty, rx_full, frame_err, overrun_err;

   int n_assert = 0;
   int n_fail = 0;
   int fe_cycles = 0;
   int ov_cycles = 0;
   int both_cycles = 0;
   int exp_fe = 0;
   int exp_ov = 0;
   int model_count = 0;
   int fall_idx;
   logic [7:0] exp_q[$];

   uart_rx_unit #(.DBIT(8), .SB_TICK(16), .DVSR(DVSR), .ADDR_W(2)) dut (
      .clk(clk), .rst(rst), .rx(rx), .rd_uart(rd_uart),
      .r_data(r_data), .rx_empty(rx_empty), .rx_full(rx_full),
      .frame_err(frame_err), .overrun_err(overrun_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_cycles++;
      if (overrun_err === 1'b1) ov_cycles++;
      if (frame_err === 1'b1 && overrun_err === 1'b1) both_cycles++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one 8N1 frame; a bad stop bit is held low only long enough to be sampled.
   task automatic send_frame(input logic [7:0] d, input bit good_stop, output int fall);
      fall = -1;
      if (good_stop) begin
         if (model_count < DEPTH) begin
            exp_q.push_back(d);
            model_count++;
         end else begin
            exp_ov++;
         end
      end else begin
         exp_fe++;
      end
      rx = 1'b0;
      wait_clks(BIT_CLK);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         wait_clks(BIT_CLK);
      end
      rx = good_stop;
      for (int i = 0; i < BIT_CLK; i++) begin
         if (!good_stop && i == 40) rx = 1'b1;
         @(posedge clk);
         #1;
         if (fall < 0 && rx_empty === 1'b0) fall = i + 1;
      end
      rx = 1'b1;
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_empty"}, 32'(rx_empty), 32'd0);
         chk({tag, "_data"}, 32'(r_data), 32'(e));
         rd_uart = 1'b1;
         wait_clks(1);
         rd_uart = 1'b0;
         model_count--;
      end
   endtask

   initial begin
      // 1. reset and idle line
      wait_clks(4);
      chk("rst_empty", 32'(rx_empty), 32'd1);
      chk("rst_full", 32'(rx_full), 32'd0);
      chk("rst_data", 32'(r_data), 32'd0);
      rst = 1'b1;
      wait_clks(2000);
      chk("idle_empty", 32'(rx_empty), 32'd1);
      chk("idle_data", 32'(r_data), 32'd0);
      chk("idle_fe", 32'(fe_cycles), 32'd0);
      chk("idle_ov", 32'(ov_cycles), 32'd0);

      // 2. single good frame, then read
      send_frame(8'h5E, 1'b1, fall_idx);
      chk("f5e_latency_window", 32'(fall_idx >= 24 && fall_idx <= 44), 32'd1);
      pop_check("f5e");
      chk("f5e_after_pop_empty", 32'(rx_empty), 32'd1);

      // 3. start-bit glitch
      rx = 1'b0;
      wait_clks(16);
      rx = 1'b1;
      wait_clks(200);
      chk("glitch_empty", 32'(rx_empty), 32'd1);
      chk("glitch_fe", 32'(fe_cycles), 32'd0);

      // 4. framing error
      send_frame(8'hA5, 1'b0, fall_idx);
      wait_clks(200);
      chk("ferr_pulses", 32'(fe_cycles), 32'(exp_fe));
      chk("ferr_empty", 32'(rx_empty), 32'd1);
      chk("ferr_no_ov", 32'(ov_cycles), 32'd0);

      // 5. five back-to-back frames into a 4-deep FIFO
      for (int k = 1; k <= 5; k++) begin
         send_frame(8'(k), 1'b1, fall_idx);
         if (k == 4) begin
            chk("b2b_full4", 32'(rx_full), 32'd1);
            chk("b2b_ov_before", 32'(ov_cycles), 32'd0);
         end
      end
      wait_clks(10);
      chk("b2b_ov_pulse", 32'(ov_cycles), 32'(exp_ov));
      chk("b2b_full5", 32'(rx_full), 32'd1);
      for (int k = 1; k <= 4; k++) pop_check($sformatf("b2b_rd%0d", k));
      chk("b2b_drained_empty", 32'(rx_empty), 32'd1);
      chk("b2b_drained_full", 32'(rx_full), 32'd0);
      rd_uart = 1'b1;
      wait_clks(1);
      rd_uart = 1'b0;
      wait_clks(1);
      chk("pop_when_empty", 32'(rx_empty), 32'd1);
      chk("pop_when_empty_full", 32'(rx_full), 32'd0);

      // 6. reset in the middle of a frame with two bytes buffered
      send_frame(8'h11, 1'b1, fall_idx);
      send_frame(8'h22, 1'b1, fall_idx);
      chk("pre_rst_empty", 32'(rx_empty), 32'd0);
      rx = 1'b0;
      wait_clks(BIT_CLK);
      rx = 1'b1;
      wait_clks(BIT_CLK);
      rx = 1'b1;
      wait_clks(BIT_CLK / 2);
      rst = 1'b0;
      rx = 1'b1;
      wait_clks(2);
      chk("midrst_empty", 32'(rx_empty), 32'd1);
      chk("midrst_data", 32'(r_data), 32'd0);
      chk("midrst_full", 32'(rx_full), 32'd0);
      exp_q.delete();
      model_count = 0;
      rst = 1'b1;
      wait_clks(100);
      chk("midrst_idle_empty", 32'(rx_empty), 32'd1);
      send_frame(8'h3C, 1'b1, fall_idx);
      pop_check("f3c");
      chk("f3c_after_pop_empty", 32'(rx_empty), 32'd1);

      chk("err_never_together", 32'(both_cycles), 32'd0);
      chk("final_fe_total", 32'(fe_cycles), 32'(exp_fe));
      chk("final_ov_total", 32'(ov_cycles), 32'(exp_ov));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
